// File: rtl/ovl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ovl_pkg
// Description : Shared constants and types for the VGA text-overlay blocks.
//               This package defines the following:
//                 - the glyph geometry
//                 - the glyph-ROM index map
//                 - the glyph-row fetch FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package ovl_pkg;

    // Glyph width and height in pixels / scanlines
    localparam int GW = 16;

    // Glyph ROM indices behind the external ROM mux
    localparam logic [2:0] GLY_R  = 3'd0;
    localparam logic [2:0] GLY_G  = 3'd1;
    localparam logic [2:0] GLY_B  = 3'd2;
    localparam logic [2:0] GLY_D0 = 3'd3;
    localparam logic [2:0] GLY_D1 = 3'd4;
    localparam logic [2:0] GLY_D2 = 3'd5;
    localparam logic [2:0] GLY_D3 = 3'd6;
    localparam logic [2:0] GLY_D4 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage : ovl_pkg
`default_nettype wire

// File: rtl/glyph_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : glyph_line_buf
// Description : This module is the scanline buffer for the glyph overlay. It
//               holds NCHAR glyph rows of GW bits each. Its ports are grouped
//               as follows.
//                 - Write side: one GW-bit slot per cycle.
//                 - Clear: a synchronous clear of the whole buffer.
//                 - Read side: a combinational read of a single bit.
//               Ports:
//                 clk, clr_n        pixel clock; asynchronous active-low reset
//                 clr               clear the whole buffer (synchronous)
//                 wr_en/wr_slot     write wr_data into slot wr_slot
//                 wr_data           glyph row, bit 0 = leftmost pixel
//                 rd_idx / rd_bit   pixel index within the band -> pixel value
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_line_buf
    import ovl_pkg::*;
#(
    parameter int NCHAR = 4,
    parameter int SW    = (NCHAR > 1) ? $clog2(NCHAR) : 1,
    parameter int IW    = $clog2(NCHAR * GW)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_slot,
    input  logic [GW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_bit
);

    logic [NCHAR*GW-1:0] bits;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bits <= '0;
        end else if (clr) begin
            bits <= '0;
        end else if (wr_en) begin
            bits[wr_slot*GW +: GW] <= wr_data;
        end
    end

    assign rd_bit = bits[rd_idx];

endmodule : glyph_line_buf
`default_nettype wire

// File: rtl/glyph_row_sched.sv
`default_nettype none
// ============================================================================
// Module      : glyph_row_sched
// Description : This module schedules the glyph-ROM fetches for the VGA text
//               overlay.
//                 - Horizontal blanking: it fetches the next scanline's glyph
//                   row for each of the NCHAR slots, over one shared ROM bus.
//                 - Active video: it outputs the buffered row as a registered
//                   1-bit overlay pixel.
//               Ports:
//                 clk, clr_n             pixel clock; asynchronous active-low reset
//                 hc, vc                 current column / scanline
//                 line_start             pulse at the start of horizontal blanking
//                 frame_start            pulse at the start of vertical blanking;
//                                        latches slot_glyph
//                 slot_glyph             glyph index per slot, [s*SELW +: SELW]
//                 rom_sel, rom_addr      shared ROM select and row address
//                 rom_data               muxed ROM row, bit 0 = leftmost pixel
//                 pix_on                 overlay pixel, one clock after hc
//                 busy                   fetch sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_row_sched
    import ovl_pkg::*;
#(
    parameter int NCHAR = 4,
    parameter int SELW  = 3,
    parameter int X0    = 16,
    parameter int Y0    = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [9:0]            hc,
    input  logic [9:0]            vc,
    input  logic                  line_start,
    input  logic                  frame_start,
    input  logic [NCHAR*SELW-1:0] slot_glyph,
    output logic [SELW-1:0]       rom_sel,
    output logic [3:0]            rom_addr,
    input  logic [15:0]           rom_data,
    output logic                  pix_on,
    output logic                  busy
);

    localparam int         SW     = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int         IW     = $clog2(NCHAR * GW);
    localparam logic [9:0] X0_V   = 10'(X0);
    localparam logic [9:0] Y0_V   = 10'(Y0);
    localparam logic [9:0] YEND_V = 10'(Y0 + GW);
    localparam logic [9:0] WIN_V  = 10'(NCHAR * GW);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NCHAR - 1);

    fetch_state_t          state;
    logic [SW-1:0]         slot;
    logic [3:0]            row;
    logic [NCHAR*SELW-1:0] shadow;

    logic [9:0] t;
    logic [9:0] px;
    logic       in_band;
    logic       buf_clr;
    logic       buf_wr;
    logic       rd_bit;

    // The fetch runs during blanking ahead of the line it serves.
    assign t       = vc + 10'd1;
    assign in_band = (t >= Y0_V) && (t < YEND_V);
    // Unsigned wrap makes columns left of X0 land far outside the window.
    assign px      = hc - X0_V;

    // A new line_start overrides an in-flight capture, so the aborted slot
    // is not written with a stale row.
    assign buf_clr = line_start && !in_band;
    assign buf_wr  = (state == ST_CAPT) && !line_start;

    // Glyph selection is frozen per frame.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shadow <= '0;
        end else if (frame_start) begin
            shadow <= slot_glyph;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            slot     <= '0;
            row      <= '0;
            rom_sel  <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
        end else if (line_start) begin
            // Start, or restart from slot 0 if a fetch is already running
            slot <= '0;
            if (in_band) begin
                row   <= 4'(t - Y0_V);
                state <= ST_ISSUE;
                busy  <= 1'b1;
            end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_ISSUE: begin
                    rom_sel  <= shadow[slot*SELW +: SELW];
                    rom_addr <= row;
                    state    <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (slot == LAST_SLOT) begin
                        state <= ST_DONE;
                    end else begin
                        slot  <= slot + SW'(1);
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    glyph_line_buf #(
        .NCHAR (NCHAR),
        .SW    (SW),
        .IW    (IW)
    ) u_line_buf (
        .clk     (clk),
        .clr_n   (clr_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_slot (slot),
        .wr_data (rom_data),
        .rd_idx  (px[IW-1:0]),
        .rd_bit  (rd_bit)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pix_on <= 1'b0;
        end else begin
            pix_on <= (px < WIN_V) && (state == ST_IDLE) && rd_bit;
        end
    end

endmodule : glyph_row_sched
`default_nettype wire

// File: tb/tb_glyph_row_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_glyph_row_sched
// Description : Directed self-checking bench for glyph_row_sched. A
//               combinational glyph-ROM model answers rom_sel/rom_addr; each
//               scenario task drives the sync inputs and compares the results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_row_sched;
    import ovl_pkg::*;

    localparam int NCHAR = 4;
    localparam int SELW  = 3;

    logic                  clk = 1'b0;
    logic                  clr_n = 1'b0;
    logic [9:0]            hc = '0;
    logic [9:0]            vc = '0;
    logic                  line_start = 1'b0;
    logic                  frame_start = 1'b0;
    logic [NCHAR*SELW-1:0] slot_glyph = '0;
    logic [SELW-1:0]       rom_sel;
    logic [3:0]            rom_addr;
    logic [15:0]           rom_data;
    logic                  pix_on;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    logic [2:0]  shadow_exp [NCHAR];
    int          nbusy;
    logic [2:0]  cap_sel  [NCHAR];
    logic [3:0]  cap_addr [NCHAR];
    logic [63:0] obs;
    int          stray;

    always #5 clk = ~clk;

    glyph_row_sched #(
        .NCHAR (NCHAR),
        .SELW  (SELW),
        .X0    (16),
        .Y0    (16)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .hc          (hc),
        .vc          (vc),
        .line_start  (line_start),
        .frame_start (frame_start),
        .slot_glyph  (slot_glyph),
        .rom_sel     (rom_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_on      (pix_on),
        .busy        (busy)
    );

    // Glyph ROM model; bit k is pixel k from the left.
    function automatic logic [15:0] rom_row(input logic [2:0] sel, input logic [3:0] addr);
        if (sel == GLY_G && addr == 4'd0)  return 16'h1FF8;  // pixels 3..12
        if (sel == GLY_G && addr == 4'd15) return 16'hE7F8;  // pixels 3..10, 13..15
        return {addr, sel, 9'h135} ^ {sel, 13'h0A5C} ^ {12'h000, addr};
    endfunction

    always_comb rom_data = rom_row(rom_sel, rom_addr);

    function automatic logic [63:0] fill_exp(input logic [3:0] row);
        logic [63:0] v;
        v = '0;
        for (int s = 0; s < NCHAR; s++) v[s*16 +: 16] = rom_row(shadow_exp[s], row);
        return v;
    endfunction

    // Pulse line_start (optionally with frame_start) and follow the fetch.
    task automatic run_fetch(input logic [9:0] v, input logic fs);
        for (int s = 0; s < NCHAR; s++) begin
            cap_sel[s]  = 'x;
            cap_addr[s] = 'x;
        end
        vc = v; line_start = 1'b1; frame_start = fs;
        @(posedge clk); #1;
        line_start = 1'b0; frame_start = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (nbusy % 2 == 0 && nbusy <= 2*NCHAR) begin
                cap_sel[nbusy/2-1]  = rom_sel;
                cap_addr[nbusy/2-1] = rom_addr;
            end
            @(posedge clk); #1;
        end
    endtask

    // Sweep hc 0..99 on scanline v and collect pixels of the 64-px window.
    task automatic sweep_line(input logic [9:0] v);
        vc = v; stray = 0; obs = '0;
        for (int h = 0; h < 100; h++) begin
            hc = 10'(h);
            @(posedge clk); #1;
            if (h >= 16 && h < 80) obs[h-16] = pix_on;
            else if (pix_on !== 1'b0) stray++;
        end
        hc = '0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        int err;
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (pix_on !== 1'b0) begin bad++; $display("FAIL reset_pix: got %b want 0", pix_on); end
        total++; if (rom_sel !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", rom_sel); end
        total++; if (rom_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        clr_n = 1'b1;
        for (int s = 0; s < NCHAR; s++) shadow_exp[s] = GLY_R;
        err = 0;
        for (int c = 0; c < 3000; c++) begin
            hc = 10'(c % 800); vc = 10'(c / 800 + 14);
            @(posedge clk); #1;
            if (busy !== 1'b0 || pix_on !== 1'b0 || rom_sel !== 3'd0 || rom_addr !== 4'd0) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL idle_quiet: got %0d bad cycles want 0", err); end
    endtask

    task automatic test_fetch();
        logic [2:0] es [NCHAR] = '{3'd1, 3'd0, 3'd1, 3'd2};
        slot_glyph = {GLY_B, GLY_G, GLY_R, GLY_G};
        pulse_frame();
        shadow_exp[0] = GLY_G; shadow_exp[1] = GLY_R; shadow_exp[2] = GLY_G; shadow_exp[3] = GLY_B;
        run_fetch(10'd15, 1'b0);
        total++; if (nbusy != 9) begin bad++; $display("FAIL fetch_busy_len: got %0d want 9", nbusy); end
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_sel[s] !== es[s]) begin bad++; $display("FAIL fetch_sel[%0d]: got %0d want %0d", s, cap_sel[s], es[s]); end
            total++; if (cap_addr[s] !== 4'd0) begin bad++; $display("FAIL fetch_addr[%0d]: got %0d want 0", s, cap_addr[s]); end
        end
        sweep_line(10'd16);
        total++; if (obs[15:0] !== 16'h1FF8) begin bad++; $display("FAIL g_row0_hc19_28: got %h want 1ff8", obs[15:0]); end
        total++; if (obs !== fill_exp(4'd0)) begin bad++; $display("FAIL line16: got %h want %h", obs, fill_exp(4'd0)); end
        total++; if (stray != 0) begin bad++; $display("FAIL line16_outside: got %0d want 0", stray); end
    endtask

    task automatic test_row15();
        run_fetch(10'd30, 1'b0);
        total++; if (nbusy != 9) begin bad++; $display("FAIL row15_busy_len: got %0d want 9", nbusy); end
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_addr[s] !== 4'd15) begin bad++; $display("FAIL row15_addr[%0d]: got %0d want 15", s, cap_addr[s]); end
        end
        sweep_line(10'd31);
        total++; if (obs[15:0] !== 16'hE7F8) begin bad++; $display("FAIL g_row15: got %h want e7f8", obs[15:0]); end
        total++; if (obs !== fill_exp(4'd15)) begin bad++; $display("FAIL line31: got %h want %h", obs, fill_exp(4'd15)); end
        run_fetch(10'd31, 1'b0);
        total++; if (nbusy != 0) begin bad++; $display("FAIL below_band_busy: got %0d want 0", nbusy); end
        sweep_line(10'd32);
        total++; if (obs !== 64'h0) begin bad++; $display("FAIL line32_cleared: got %h want 0", obs); end
    endtask

    task automatic test_abort();
        vc = 10'd20; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        run_fetch(10'd22, 1'b0);
        total++; if (nbusy != 9) begin bad++; $display("FAIL abort_busy_len: got %0d want 9", nbusy); end
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_addr[s] !== 4'd7) begin bad++; $display("FAIL abort_addr[%0d]: got %0d want 7", s, cap_addr[s]); end
        end
        sweep_line(10'd23);
        total++; if (obs !== fill_exp(4'd7)) begin bad++; $display("FAIL abort_line: got %h want %h", obs, fill_exp(4'd7)); end
    endtask

    task automatic test_reset_mid();
        vc = 10'd29; line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1 || rom_addr !== 4'd14) begin bad++; $display("FAIL mid_pre: got busy=%b addr=%0d want busy=1 addr=14", busy, rom_addr); end
        clr_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        total++; if (rom_addr !== 4'd0 || rom_sel !== 3'd0) begin bad++; $display("FAIL mid_rst_rom: got addr=%0d sel=%0d want 0 0", rom_addr, rom_sel); end
        #2;
        clr_n = 1'b1;
        for (int s = 0; s < NCHAR; s++) shadow_exp[s] = GLY_R;
        sweep_line(10'd30);
        total++; if (obs !== 64'h0) begin bad++; $display("FAIL mid_rst_buf: got %h want 0", obs); end
        run_fetch(10'd29, 1'b0);
        total++; if (nbusy != 9) begin bad++; $display("FAIL post_rst_busy_len: got %0d want 9", nbusy); end
        sweep_line(10'd30);
        total++; if (obs !== fill_exp(4'd14)) begin bad++; $display("FAIL post_rst_line: got %h want %h", obs, fill_exp(4'd14)); end
    endtask

    task automatic test_shadow();
        logic [2:0] es [NCHAR] = '{3'd3, 3'd4, 3'd5, 3'd6};
        slot_glyph = {GLY_D3, GLY_D2, GLY_D1, GLY_D0};
        run_fetch(10'd20, 1'b0);
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_sel[s] !== 3'd0) begin bad++; $display("FAIL shadow_hold_sel[%0d]: got %0d want 0", s, cap_sel[s]); end
        end
        sweep_line(10'd21);
        total++; if (obs !== fill_exp(4'd5)) begin bad++; $display("FAIL shadow_hold_line: got %h want %h", obs, fill_exp(4'd5)); end
        pulse_frame();
        for (int s = 0; s < NCHAR; s++) shadow_exp[s] = es[s];
        run_fetch(10'd21, 1'b0);
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_sel[s] !== es[s]) begin bad++; $display("FAIL shadow_new_sel[%0d]: got %0d want %0d", s, cap_sel[s], es[s]); end
        end
        sweep_line(10'd22);
        total++; if (obs !== fill_exp(4'd6)) begin bad++; $display("FAIL shadow_new_line: got %h want %h", obs, fill_exp(4'd6)); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] es [NCHAR] = '{3'd4, 3'd1, 3'd2, 3'd7};
        slot_glyph = {GLY_D4, GLY_B, GLY_G, GLY_D1};
        for (int s = 0; s < NCHAR; s++) shadow_exp[s] = es[s];
        run_fetch(10'd25, 1'b1);
        total++; if (nbusy != 9) begin bad++; $display("FAIL coincide_busy_len: got %0d want 9", nbusy); end
        for (int s = 0; s < NCHAR; s++) begin
            total++; if (cap_sel[s] !== es[s]) begin bad++; $display("FAIL coincide_sel[%0d]: got %0d want %0d", s, cap_sel[s], es[s]); end
        end
        sweep_line(10'd26);
        total++; if (obs !== fill_exp(4'd10)) begin bad++; $display("FAIL coincide_line: got %h want %h", obs, fill_exp(4'd10)); end
        run_fetch(10'd14, 1'b0);
        total++; if (nbusy != 0) begin bad++; $display("FAIL above_band_busy: got %0d want 0", nbusy); end
        sweep_line(10'd15);
        total++; if (obs !== 64'h0) begin bad++; $display("FAIL above_band_line: got %h want 0", obs); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_row15();
        test_abort();
        test_reset_mid();
        test_shadow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_glyph_row_sched
`default_nettype wire
